// File: rtl/router_pkt_param.sv
// router_pkt_param
// Store-and-forward packet router. A byte-serial input stream
// (header, L payload bytes, parity byte) is steered into one of NUM_CH
// channel FIFOs. Payload is written speculatively and becomes visible to
// the reader only after the parity byte matches; failed, truncated or
// oversized packets are rolled back.
//
// Optional feature: define ROUTER_TIMEOUT_EN to build a per-channel read
// timeout that flushes committed data left unread for TIMEOUT_CYCLES.
//
// Ports:
//   clk          in   rising-edge clock
//   resetn       in   asynchronous active-low reset
//   packet_valid in   datain carries a byte
//   datain       in   header / payload / parity byte
//   read_enb     in   per-channel pop request
//   busy         out  input stall
//   err          out  one-cycle pulse when a packet is discarded
//   vldout       out  per-channel "committed data present"
//   data_out     out  show-ahead FIFO heads, channel c at [c*DATA_W +: DATA_W]
//   o_dbg_state  out  current FSM state (debug visibility)
//
// Handshake: a byte transfers on a rising edge where packet_valid = 1 and
// busy = 0. busy depends only on registered state, never on datain.
// A pop happens on a rising edge where read_enb[c] = 1 and vldout[c] = 1.
module router_pkt_param #(
    parameter int DATA_W         = 8,
    parameter int NUM_CH         = 3,
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 30
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       packet_valid,
    input  logic [DATA_W-1:0]          datain,
    input  logic [NUM_CH-1:0]          read_enb,
    output logic                       busy,
    output logic                       err,
    output logic [NUM_CH-1:0]          vldout,
    output logic [NUM_CH*DATA_W-1:0]   data_out,
    output logic [2:0]                 o_dbg_state
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int PW  = AW + 1;
    localparam int LW  = DATA_W - 2;
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_LOAD  = 3'd2,
        S_CHECK = 3'd3,
        S_DROP  = 3'd4
    } state_t;

    state_t            r_state;
    logic [CHW-1:0]    r_dest;
    logic [LW-1:0]     r_len;
    logic [LW-1:0]     r_cnt;
    logic [DATA_W-1:0] r_par;
    logic              r_par_ok;
    logic              r_err;
    logic [PW-1:0]     r_rd_ptr     [NUM_CH];
    logic [PW-1:0]     r_commit_ptr [NUM_CH];
    logic [PW-1:0]     r_spec_ptr   [NUM_CH];
    logic [DATA_W-1:0] r_mem        [NUM_CH][FIFO_DEPTH];

`ifdef ROUTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0]     r_to_cnt     [NUM_CH];
`endif

    logic [NUM_CH-1:0] w_vld;
    logic [PW-1:0]     w_used [NUM_CH];
    logic [31:0]       w_free [NUM_CH];
    logic [1:0]        w_hdr_dest;
    logic [LW-1:0]     w_hdr_len;
    logic [31:0]       w_hdr_free;
    logic [31:0]       w_dest_free;
    logic              w_hdr_bad;
    logic              w_wr_en;

    assign w_hdr_dest = datain[1:0];
    assign w_hdr_len  = datain[DATA_W-1:2];

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            // Pointers carry one extra wrap bit, so plain subtraction gives
            // the occupancy even across the wrap.
            w_used[c] = r_spec_ptr[c] - r_rd_ptr[c];
            w_free[c] = FIFO_DEPTH - 32'(w_used[c]);
            w_vld[c]  = (r_commit_ptr[c] != r_rd_ptr[c]);
        end
        // A destination outside NUM_CH is dropped anyway; its free value is
        // never used.
        w_hdr_free = 32'(FIFO_DEPTH);
        for (int c = 0; c < NUM_CH; c++) begin
            if (32'(w_hdr_dest) == 32'(c)) begin
                w_hdr_free = w_free[c];
            end
        end
    end

    assign w_dest_free = w_free[r_dest];
    assign w_hdr_bad   = (32'(w_hdr_dest) >= 32'(NUM_CH)) ||
                         (32'(w_hdr_len) > 32'(FIFO_DEPTH));
    assign w_wr_en     = (r_state == S_LOAD) && packet_valid && (r_cnt != r_len);

    // Payload storage; no reset needed because visibility is governed by
    // the pointers alone.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_dest][r_spec_ptr[r_dest][AW-1:0]] <= datain;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_dest   <= '0;
            r_len    <= '0;
            r_cnt    <= '0;
            r_par    <= '0;
            r_par_ok <= 1'b0;
            r_err    <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_rd_ptr[c]     <= '0;
                r_commit_ptr[c] <= '0;
                r_spec_ptr[c]   <= '0;
`ifdef ROUTER_TIMEOUT_EN
                r_to_cnt[c]     <= '0;
`endif
            end
        end else begin
            r_err <= 1'b0;

            // Read side: pops only touch rd_ptr, so they never collide with
            // the writer, which only touches spec_ptr / commit_ptr.
            for (int c = 0; c < NUM_CH; c++) begin
                if (read_enb[c] && w_vld[c]) begin
                    r_rd_ptr[c] <= r_rd_ptr[c] + 1'b1;
`ifdef ROUTER_TIMEOUT_EN
                    r_to_cnt[c] <= '0;
                end else if (!w_vld[c]) begin
                    r_to_cnt[c] <= '0;
                end else if (r_to_cnt[c] == TO_LAST) begin
                    // Flush committed data only; an in-flight packet lives
                    // beyond commit_ptr and is untouched.
                    r_rd_ptr[c] <= r_commit_ptr[c];
                    r_to_cnt[c] <= '0;
                end else begin
                    r_to_cnt[c] <= r_to_cnt[c] + 1'b1;
`endif
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (packet_valid) begin
                        r_dest <= datain[CHW-1:0];
                        r_len  <= w_hdr_len;
                        r_cnt  <= '0;
                        r_par  <= datain;
                        if (w_hdr_bad) begin
                            r_state <= S_DROP;
                            r_err   <= 1'b1;
                        end else if (32'(w_hdr_len) > w_hdr_free) begin
                            r_state <= S_WAIT;
                        end else begin
                            r_state <= S_LOAD;
                        end
                    end
                end
                S_WAIT: begin
                    if (32'(r_len) <= w_dest_free) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (!packet_valid) begin
                        // Truncated packet: roll back the speculative bytes.
                        r_spec_ptr[r_dest] <= r_commit_ptr[r_dest];
                        r_err              <= 1'b1;
                        r_state            <= S_IDLE;
                    end else if (r_cnt != r_len) begin
                        r_spec_ptr[r_dest] <= r_spec_ptr[r_dest] + 1'b1;
                        r_par              <= r_par ^ datain;
                        r_cnt              <= r_cnt + 1'b1;
                    end else begin
                        r_par_ok <= (r_par == datain);
                        r_state  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (r_par_ok) begin
                        r_commit_ptr[r_dest] <= r_spec_ptr[r_dest];
                    end else begin
                        r_spec_ptr[r_dest] <= r_commit_ptr[r_dest];
                        r_err              <= 1'b1;
                    end
                    r_state <= S_IDLE;
                end
                S_DROP: begin
                    if (!packet_valid) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy        = (r_state == S_WAIT) || (r_state == S_CHECK);
    assign err         = r_err;
    assign vldout      = w_vld;
    assign o_dbg_state = r_state;

    always_comb begin
        data_out = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_vld[c]) begin
                data_out[c*DATA_W +: DATA_W] = r_mem[c][r_rd_ptr[c][AW-1:0]];
            end
        end
    end

endmodule

// File: tb/tb_router_pkt_param.sv
// Directed bench for router_pkt_param at default parameters
// (DATA_W=8, NUM_CH=3, FIFO_DEPTH=16). Expected bytes are hand-computed.
module tb_router_pkt_param;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        packet_valid = 1'b0;
    logic [7:0]  datain = 8'h00;
    logic [2:0]  read_enb = 3'b000;
    logic        busy;
    logic        err;
    logic [2:0]  vldout;
    logic [23:0] data_out;
    logic [2:0]  dbg_state;

    router_pkt_param #(
        .DATA_W(8), .NUM_CH(3), .FIFO_DEPTH(16), .TIMEOUT_CYCLES(30)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .packet_valid (packet_valid),
        .datain       (datain),
        .read_enb     (read_enb),
        .busy         (busy),
        .err          (err),
        .vldout       (vldout),
        .data_out     (data_out),
        .o_dbg_state  (dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int err_cnt = 0;
    int e0;

    logic [7:0] pkt_q[$];
    logic [7:0] exp_q[$];

    always @(negedge clk) begin
        if (err === 1'b1) err_cnt++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Driver tasks; all are entered and left #1 after a rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        packet_valid = 1'b1;
        datain = b;
        while (busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) check("busy_stuck", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic send_q();
        while (pkt_q.size() > 0) send_byte(pkt_q.pop_front());
    endtask

    // Scoreboard: compare the channel head with exp_q, popping one per cycle.
    task automatic drain(input int c);
        logic [7:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rd_vld", 32'(vldout[c]), 32'd1);
            check("rd_data", 32'(data_out[c*8 +: 8]), 32'(e));
            read_enb[c] = 1'b1;
            tick(1);
            read_enb = 3'b000;
        end
        check("drained_vld", 32'(vldout[c]), 32'd0);
        check("drained_data", 32'(data_out[c*8 +: 8]), 32'd0);
    endtask

    initial begin
        // Reset state
        tick(2);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_vld", 32'(vldout), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        resetn = 1'b1;
        tick(1);

        // Good packet to ch1: L=3
        e0 = err_cnt;
        pkt_q = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
        send_q();
        packet_valid = 1'b0;
        check("chk_busy", 32'(busy), 32'd1);
        check("chk_vld_early", 32'(vldout), 32'd0);
        tick(1);
        check("good_vld", 32'(vldout), 32'b010);
        exp_q = '{8'h11, 8'h22, 8'h33};
        drain(1);
        check("good_noerr", 32'(err_cnt - e0), 32'd0);

        // Parity error, then a good packet on the same channel
        pkt_q = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0C};
        send_q();
        packet_valid = 1'b0;
        tick(1);
        check("par_err_hi", 32'(err), 32'd1);
        check("par_vld", 32'(vldout), 32'd0);
        tick(1);
        check("par_err_lo", 32'(err), 32'd0);
        pkt_q = '{8'h09, 8'hAA, 8'h55, 8'hF6};
        send_q();
        packet_valid = 1'b0;
        tick(1);
        check("after_par_vld", 32'(vldout), 32'b010);
        exp_q = '{8'hAA, 8'h55};
        drain(1);

        // Zero-length packet: nothing becomes visible, no error
        e0 = err_cnt;
        pkt_q = '{8'h01, 8'h01};
        send_q();
        packet_valid = 1'b0;
        tick(2);
        check("l0_vld", 32'(vldout), 32'd0);
        check("l0_noerr", 32'(err_cnt - e0), 32'd0);

        // Invalid destination 3
        e0 = err_cnt;
        pkt_q = '{8'h07, 8'h01, 8'h02, 8'h03};
        send_q();
        packet_valid = 1'b0;
        tick(2);
        check("dest_err", 32'(err_cnt - e0), 32'd1);
        check("dest_vld", 32'(vldout), 32'd0);

        // Oversized length 17 > FIFO_DEPTH
        e0 = err_cnt;
        pkt_q = '{8'h44, 8'h00};
        send_q();
        packet_valid = 1'b0;
        tick(2);
        check("big_err", 32'(err_cnt - e0), 32'd1);
        check("big_vld", 32'(vldout), 32'd0);

        // Backpressure: 12 committed in ch0, then L=8 must wait for 4 pops
        e0 = err_cnt;
        pkt_q = '{8'h30, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                  8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h3C};
        send_q();
        packet_valid = 1'b0;
        tick(1);
        check("bp_vld", 32'(vldout), 32'b001);
        packet_valid = 1'b1;
        datain = 8'h20;
        tick(1);
        check("bp_busy_wait", 32'(busy), 32'd1);
        datain = 8'hB0;
        for (int i = 1; i <= 4; i++) begin
            check("bp_pop", 32'(data_out[7:0]), 32'(i));
            read_enb = 3'b001;
            tick(1);
            read_enb = 3'b000;
        end
        check("bp_busy_still", 32'(busy), 32'd1);
        tick(1);
        check("bp_busy_free", 32'(busy), 32'd0);
        pkt_q = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6, 8'hB7, 8'h20};
        send_q();
        packet_valid = 1'b0;
        tick(1);
        exp_q = '{8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C,
                  8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6, 8'hB7};
        drain(0);
        check("bp_noerr", 32'(err_cnt - e0), 32'd0);

        // Truncation: 2 of 5 payload bytes to ch2, then a good packet
        e0 = err_cnt;
        pkt_q = '{8'h16, 8'h01, 8'h02};
        send_q();
        packet_valid = 1'b0;
        tick(2);
        check("trunc_err", 32'(err_cnt - e0), 32'd1);
        check("trunc_vld", 32'(vldout), 32'd0);
        pkt_q = '{8'h06, 8'h5A, 8'h5C};
        send_q();
        packet_valid = 1'b0;
        tick(1);
        check("trunc_next_vld", 32'(vldout), 32'b100);
        exp_q = '{8'h5A};
        drain(2);

        // Reset mid-LOAD discards committed data as well
        pkt_q = '{8'h05, 8'h77, 8'h72};
        send_q();
        packet_valid = 1'b0;
        tick(1);
        check("pre_rst_vld", 32'(vldout), 32'b010);
        pkt_q = '{8'h0D, 8'h11};
        send_q();
        check("pre_rst_state", 32'(dbg_state), 32'd2);
        #2;
        resetn = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        check("mid_rst_vld", 32'(vldout), 32'd0);
        check("mid_rst_data", 32'(data_out), 32'd0);
        packet_valid = 1'b0;
        tick(1);
        resetn = 1'b1;
        tick(2);
        check("post_rst_vld", 32'(vldout), 32'd0);
        pkt_q = '{8'h09, 8'hAA, 8'h55, 8'hF6};
        send_q();
        packet_valid = 1'b0;
        tick(1);
        exp_q = '{8'hAA, 8'h55};
        drain(1);

`ifdef ROUTER_TIMEOUT_EN
        // Unread data in ch2 is flushed after 30 cycles
        pkt_q = '{8'h0A, 8'h01, 8'h02, 8'h09};
        send_q();
        packet_valid = 1'b0;
        tick(1);
        check("to_vld", 32'(vldout), 32'b100);
        tick(25);
        check("to_hold", 32'(vldout), 32'b100);
        tick(10);
        check("to_flush", 32'(vldout), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
